// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter. Serialises a parallel byte LSB-first as
// start / data / optional parity / stop, holding each bit for 'prescaler' CLK cycles.
// Ports:
//   CLK, RST          clock (rising edge), asynchronous active-high reset
//   P_DATA/Data_Valid payload and request; accepted only while idle
//   PAR_EN/PAR_TYP    parity enable, parity type (0 even, 1 odd)
//   prescaler         CLK cycles per bit; 0 means 2^PRESC_WIDTH
//   TX_OUT            serial line, idle high (registered)
//   Busy              frame in progress (registered)
module uart_tx_frame #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned PRESC_WIDTH = 6
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [DATA_WIDTH-1:0]  P_DATA,
  input  logic                   Data_Valid,
  input  logic                   PAR_EN,
  input  logic                   PAR_TYP,
  input  logic [PRESC_WIDTH-1:0] prescaler,
  output logic                   TX_OUT,
  output logic                   Busy
);

  localparam int unsigned BitCntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                 r_state,    w_state_nxt;
  logic [PRESC_WIDTH-1:0] r_edge_cnt, w_edge_nxt;
  logic [BitCntW-1:0]     r_bit_cnt,  w_bit_nxt;
  logic [DATA_WIDTH-1:0]  r_data,     w_data_nxt;
  logic                   r_par_en,   w_par_en_nxt;
  logic                   r_par_typ,  w_par_typ_nxt;
  logic [PRESC_WIDTH-1:0] r_presc,    w_presc_nxt;
  logic                   r_tx,       w_tx_nxt;
  logic                   r_busy,     w_busy_nxt;

  logic w_bit_done;
  logic w_par_bit;

  // Wrap arithmetic makes prescaler 0 compare against all-ones, i.e. 2^PRESC_WIDTH cycles.
  assign w_bit_done = (r_edge_cnt == (r_presc - PRESC_WIDTH'(1)));
  assign w_par_bit  = r_par_typ ? ~^r_data : ^r_data;

  always_comb begin
    w_state_nxt   = r_state;
    w_edge_nxt    = r_edge_cnt;
    w_bit_nxt     = r_bit_cnt;
    w_data_nxt    = r_data;
    w_par_en_nxt  = r_par_en;
    w_par_typ_nxt = r_par_typ;
    w_presc_nxt   = r_presc;
    w_tx_nxt      = r_tx;
    w_busy_nxt    = r_busy;

    if (r_state != StIdle) begin
      w_edge_nxt = w_bit_done ? '0 : r_edge_cnt + PRESC_WIDTH'(1);
    end

    unique case (r_state)
      StIdle: begin
        w_edge_nxt = '0;
        w_tx_nxt   = 1'b1;
        w_busy_nxt = 1'b0;
        if (Data_Valid) begin
          // Shadow the whole configuration so later input changes cannot corrupt this frame.
          w_data_nxt    = P_DATA;
          w_par_en_nxt  = PAR_EN;
          w_par_typ_nxt = PAR_TYP;
          w_presc_nxt   = prescaler;
          w_bit_nxt     = '0;
          w_state_nxt   = StStart;
          w_tx_nxt      = 1'b0;
          w_busy_nxt    = 1'b1;
        end
      end
      StStart: begin
        if (w_bit_done) begin
          w_state_nxt = StData;
          w_bit_nxt   = '0;
          w_tx_nxt    = r_data[0];
        end
      end
      StData: begin
        if (w_bit_done) begin
          if (r_bit_cnt == LastBit) begin
            if (r_par_en) begin
              w_state_nxt = StParity;
              w_tx_nxt    = w_par_bit;
            end else begin
              w_state_nxt = StStop;
              w_tx_nxt    = 1'b1;
            end
          end else begin
            w_bit_nxt = r_bit_cnt + BitCntW'(1);
            w_tx_nxt  = r_data[r_bit_cnt + BitCntW'(1)];
          end
        end
      end
      StParity: begin
        if (w_bit_done) begin
          w_state_nxt = StStop;
          w_tx_nxt    = 1'b1;
        end
      end
      StStop: begin
        if (w_bit_done) begin
          w_state_nxt = StIdle;
          w_busy_nxt  = 1'b0;
          w_tx_nxt    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = StIdle;
        w_tx_nxt    = 1'b1;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= StIdle;
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
      r_data     <= '0;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_presc    <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_edge_cnt <= w_edge_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_data     <= w_data_nxt;
      r_par_en   <= w_par_en_nxt;
      r_par_typ  <= w_par_typ_nxt;
      r_presc    <= w_presc_nxt;
      r_tx       <= w_tx_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign TX_OUT = r_tx;
  assign Busy   = r_busy;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: self-checking bench for uart_tx_frame. Expected frames are built from a
// vector table and queued when a request is driven; they are popped and compared cycle by
// cycle against TX_OUT / Busy as the frame is shifted out.
module tb_uart_tx_frame;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] prescaler;
  logic       TX_OUT;
  logic       Busy;

  uart_tx_frame #(
    .DATA_WIDTH (8),
    .PRESC_WIDTH(6)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .Data_Valid(Data_Valid),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .prescaler (prescaler),
    .TX_OUT    (TX_OUT),
    .Busy      (Busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       pt;
    logic [5:0] presc;
    logic       exp_par;
    int         exp_busy;
  } vec_t;

  typedef struct {
    logic [11:0] bits;
    int          nbits;
    int          p;
    int          exp_busy;
  } frame_t;

  frame_t sb_q[$];
  vec_t   vecs[7];
  int     n_checks = 0;
  int     n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Drive a request (call at a negedge) and optionally queue the expected frame.
  task automatic start_frame(input logic [7:0] d, input logic pe, input logic pt,
                             input logic [5:0] ps, input logic exp_par, input int exp_busy,
                             input bit push);
    frame_t f;
    f.bits    = '1;
    f.bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) f.bits[i+1] = d[i];
    f.bits[9]  = pe ? exp_par : 1'b1;
    f.bits[10] = 1'b1;
    f.nbits    = pe ? 11 : 10;
    f.p        = (ps == 6'd0) ? 64 : int'(ps);
    f.exp_busy = exp_busy;
    if (push) sb_q.push_back(f);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    prescaler  = ps;
    Data_Valid = 1'b1;
    @(negedge CLK);
  endtask

  // Entered at the first negedge after the accept edge; returns at the first idle sample.
  task automatic check_frame(input int inject_cyc, input bit keep_dv, input logic [7:0] next_data);
    frame_t f;
    int busy_cnt;
    int k;
    busy_cnt = 0;
    k = 0;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    f = sb_q.pop_front();
    if (!keep_dv) Data_Valid = 1'b0;
    P_DATA = next_data;
    for (int b = 0; b < f.nbits; b++) begin
      for (int c = 0; c < f.p; c++) begin
        if (inject_cyc >= 0 && k == inject_cyc) begin
          Data_Valid = 1'b1;
          P_DATA     = 8'hFF;
          prescaler  = 6'd8;
        end else if (inject_cyc >= 0 && k == inject_cyc + 1) begin
          Data_Valid = 1'b0;
        end
        chk($sformatf("tx_bit%0d_cyc%0d", b, c), {31'd0, TX_OUT}, {31'd0, f.bits[b]});
        if (Busy === 1'b1) busy_cnt++;
        k++;
        @(negedge CLK);
      end
    end
    chk("busy_len", busy_cnt, f.exp_busy);
    chk("idle_tx", {31'd0, TX_OUT}, 32'd1);
    chk("idle_busy", {31'd0, Busy}, 32'd0);
  endtask

  initial begin
    RST        = 1'b1;
    P_DATA     = 8'h00;
    Data_Valid = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    prescaler  = 6'd4;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 6'd4, 1'b0, 40};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, 6'd4, 1'b0, 44};
    vecs[2] = '{8'hA5, 1'b1, 1'b1, 6'd4, 1'b1, 44};
    vecs[3] = '{8'hA5, 1'b0, 1'b0, 6'd1, 1'b0, 10};
    vecs[4] = '{8'h07, 1'b1, 1'b0, 6'd3, 1'b1, 33};
    vecs[5] = '{8'h80, 1'b1, 1'b1, 6'd2, 1'b0, 22};
    vecs[6] = '{8'h5A, 1'b0, 1'b0, 6'd0, 1'b0, 640};

    // Reset state
    #12;
    chk("rst_tx", {31'd0, TX_OUT}, 32'd1);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("idle_after_rst_tx", {31'd0, TX_OUT}, 32'd1);

    // Table-driven frames
    for (int i = 0; i < 7; i++) begin
      start_frame(vecs[i].data, vecs[i].pe, vecs[i].pt, vecs[i].presc,
                  vecs[i].exp_par, vecs[i].exp_busy, 1'b1);
      check_frame(-1, 1'b0, ~vecs[i].data);
      repeat (2) @(negedge CLK);
    end

    // Request and prescaler change mid-frame must not disturb the frame or be queued
    start_frame(8'hA5, 1'b0, 1'b0, 6'd4, 1'b0, 40, 1'b1);
    check_frame(10, 1'b0, 8'h00);
    for (int i = 0; i < 20; i++) begin
      chk("no_queued_tx", {31'd0, TX_OUT}, 32'd1);
      chk("no_queued_busy", {31'd0, Busy}, 32'd0);
      @(negedge CLK);
    end

    // Data_Valid held: two frames with exactly one idle-high cycle between them
    start_frame(8'h3C, 1'b0, 1'b0, 6'd4, 1'b0, 40, 1'b1);
    check_frame(-1, 1'b1, 8'hC3);
    start_frame(8'hC3, 1'b0, 1'b0, 6'd4, 1'b0, 40, 1'b1);
    check_frame(-1, 1'b0, 8'h00);
    repeat (2) @(negedge CLK);

    // Asynchronous reset during data bit 3 (a 0 bit of 0xA5)
    start_frame(8'hA5, 1'b0, 1'b0, 6'd4, 1'b0, 40, 1'b0);
    Data_Valid = 1'b0;
    repeat (17) @(negedge CLK);
    chk("pre_rst_bit3", {31'd0, TX_OUT}, 32'd0);
    chk("pre_rst_busy", {31'd0, Busy}, 32'd1);
    #1 RST = 1'b1;
    #1;
    chk("async_rst_tx", {31'd0, TX_OUT}, 32'd1);
    chk("async_rst_busy", {31'd0, Busy}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("post_rst_tx", {31'd0, TX_OUT}, 32'd1);
    chk("post_rst_busy", {31'd0, Busy}, 32'd0);
    start_frame(8'h96, 1'b1, 1'b0, 6'd4, 1'b0, 44, 1'b1);
    check_frame(-1, 1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
